perceptron_cmd_parser: RTL and testbench
========================================

// Module: perceptron_cmd_parser
// PURPOSE
//  Frame decoder between the UART receiver and the perceptron core. Collects
//  6-byte host frames {SYNC, OP, D0, D1, D2, D3}, validates them and presents
//  one command {op, 32-bit data} to the core over a valid/ready handshake.
//  Malformed, stale or overrun traffic is dropped and flagged with error pulses.
// PARAMETERS
//  SYNC_BYTE   8'd100   frame start marker
//  OP_MASK     8'h67    bit n set => opcode n legal (0,1,2,5,6); opcodes >=8 illegal
//  TIMEOUT     50000    max clocks between bytes inside a frame (1 ms at 50 MHz)
//  TO_W        16       width of the gap counter; must hold TIMEOUT
// PORTS
//  clk          in   1   system clock
//  nRst         in   1   asynchronous active-low reset
//  rx_valid     in   1   one-cycle strobe: rx_data holds a received byte
//  rx_data      in   8   received byte
//  cmd_valid    out  1   command available
//  cmd_ready    in   1   core accepts command when cmd_valid && cmd_ready
//  cmd_op       out  8   opcode
//  cmd_data     out  32  payload, D0 = [7:0], D1 = [15:8], D2 = [23:16], D3 = [31:24]
//  err_op       out  1   1-cycle pulse: complete frame dropped, illegal opcode
//  err_timeout  out  1   1-cycle pulse: partial frame abandoned, gap > TIMEOUT
//  err_overrun  out  1   1-cycle pulse: byte arrived while a command was pending
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, byte count 0, gap counter 0.
//  States:
//   IDLE  - rx_valid && rx_data==SYNC_BYTE -> OP. Other bytes ignored, no error.
//   OP    - next byte latched as opcode -> DATA, count=0.
//   DATA  - each byte written to cmd_data[8*count +: 8], count++.
//           On the 4th byte: opcode legal -> HOLD, cmd_valid=1 the next cycle;
//           illegal -> err_op pulse, go to IDLE.
//   HOLD  - cmd_valid held high; cmd_op/cmd_data stable until the handshake.
//           On cmd_valid && cmd_ready: cmd_valid=0 next cycle -> IDLE.
//  Latency: last payload byte strobe at cycle N -> cmd_valid high at N+1.
//  Ready may already be high: the handshake completes at N+1, and a SYNC byte
//  at N+2 is accepted.
//  SYNC_BYTE is not special in OP or DATA. A value of 100 is data there.
//  Gap timer (OP, DATA only):
//   - clears on every accepted byte and increments each cycle otherwise;
//   - reaching TIMEOUT -> err_timeout pulse, go to IDLE, payload discarded;
//   - a byte on the same cycle as the timeout is dropped; the timeout wins.
//  Overrun: rx_valid in HOLD -> byte dropped, err_overrun pulse, command kept.
//  If rx_valid and the handshake land on the same cycle in HOLD, the byte is
//  still an overrun. The handshake completes normally.
//  No timeout in HOLD: the core may stall indefinitely.
//  Async reset mid-frame or in HOLD: immediate return to reset values; the
//  partial or pending command is lost.
//  At most one error pulse per cycle; the error outputs are mutually exclusive.
// TESTING
//  1 Bytes 100,0,1,2,3,4, ready=1 -> one cycle of cmd_valid, op=0,
//    data=32'h04030201, no errors.
//  2 Bytes 100,5,10,20,30,40, ready low for 20 cycles -> cmd_valid stays high
//    and outputs stay stable for 20 cycles; accepted on the cycle ready rises;
//    op=5, data=32'h281E140A.
//  3 Bytes 100,3,1,2,3,4 -> err_op pulse once, cmd_valid never asserted,
//    next legal frame decodes correctly.
//  4 Bytes 100,6,10 then silence for TIMEOUT cycles -> err_timeout pulse, back in
//    IDLE; following frame 100,1,10,20,30,40 -> op=1, data=32'h281E140A.
//  5 Legal frame with ready=0, then byte 7 -> err_overrun pulse, pending command
//    unchanged and delivered when ready=1.
//  6 Stray bytes 7,9 before SYNC and payload 100,100,100,100 after op 2 ->
//    strays ignored, op=2, data=32'h64646464; nRst pulsed after the 3rd byte of
//    another frame -> no cmd_valid, clean decode of the next frame.

Source files
------------

// File: rtl/perceptron_cmd_parser.sv
// ============================================================================
// perceptron_cmd_parser : UART frame decoder {SYNC,OP,D0..D3} -> valid/ready command
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module perceptron_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE = 8'd100,
  parameter logic [7:0] OP_MASK   = 8'h67,
  parameter int         TIMEOUT   = 50000,
  parameter int         TO_W      = 16
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [31:0] cmd_data,
  output logic        err_op,
  output logic        err_timeout,
  output logic        err_overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_DATA = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [TO_W-1:0]   gap_q, gap_d;
  logic [7:0]        op_q, op_d;
  logic [31:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_op_q, err_op_d;
  logic              err_to_q, err_to_d;
  logic              err_ov_q, err_ov_d;

  logic              timed_out;
  logic              op_legal;

  // Timeout fires once the gap counter has reached TIMEOUT; a byte arriving
  // on that same cycle is dropped.
  assign timed_out = (gap_q == TIMEOUT_C);
  assign op_legal  = (op_q[7:3] == 5'd0) && OP_MASK[op_q[2:0]];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    op_d     = op_q;
    data_d   = data_q;
    valid_d  = valid_q;
    err_op_d = 1'b0;
    err_to_d = 1'b0;
    err_ov_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        gap_d = '0;
        cnt_d = 2'd0;
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = S_OP;
        end
      end

      S_OP: begin
        if (timed_out) begin
          err_to_d = 1'b1;
          gap_d    = '0;
          state_d  = S_IDLE;
        end else if (rx_valid) begin
          op_d    = rx_data;
          cnt_d   = 2'd0;
          gap_d   = '0;
          state_d = S_DATA;
        end else begin
          gap_d = gap_q + TO_W'(1);
        end
      end

      S_DATA: begin
        if (timed_out) begin
          err_to_d = 1'b1;
          gap_d    = '0;
          state_d  = S_IDLE;
        end else if (rx_valid) begin
          data_d[{cnt_q, 3'b000} +: 8] = rx_data;
          cnt_d = cnt_q + 2'd1;
          gap_d = '0;
          if (cnt_q == 2'd3) begin
            if (op_legal) begin
              valid_d = 1'b1;
              state_d = S_HOLD;
            end else begin
              err_op_d = 1'b1;
              state_d  = S_IDLE;
            end
          end
        end else begin
          gap_d = gap_q + TO_W'(1);
        end
      end

      S_HOLD: begin
        gap_d = '0;
        // Bytes here are lost even if the handshake completes this cycle.
        if (rx_valid) begin
          err_ov_d = 1'b1;
        end
        if (valid_q && cmd_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      gap_q    <= '0;
      op_q     <= 8'd0;
      data_q   <= 32'd0;
      valid_q  <= 1'b0;
      err_op_q <= 1'b0;
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      op_q     <= op_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_op_q <= err_op_d;
      err_to_q <= err_to_d;
      err_ov_q <= err_ov_d;
    end
  end

  assign cmd_valid   = valid_q;
  assign cmd_op      = op_q;
  assign cmd_data    = data_q;
  assign err_op      = err_op_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;

endmodule

`default_nettype wire

// File: tb/tb_perceptron_cmd_parser.sv
// ============================================================================
// tb_perceptron_cmd_parser : directed self-checking bench for the frame decoder
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_perceptron_cmd_parser;

  localparam int TIMEOUT = 40;

  logic        clk;
  logic        nRst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        err_op;
  logic        err_timeout;
  logic        err_overrun;

  int checks;
  int errors;

  perceptron_cmd_parser #(
    .SYNC_BYTE (8'd100),
    .OP_MASK   (8'h67),
    .TIMEOUT   (TIMEOUT),
    .TO_W      (16)
  ) dut (
    .clk         (clk),
    .nRst        (nRst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .err_op      (err_op),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All drivers are called 1 time unit after a rising edge and return the same way.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] d);
    send_byte(8'd100);
    send_byte(op);
    send_byte(d[7:0]);
    send_byte(d[15:8]);
    send_byte(d[23:16]);
    send_byte(d[31:24]);
  endtask

  task automatic test_reset;
    nRst      = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    cmd_ready = 1'b0;
    step(2);
    checks++;
    if ({cmd_valid, err_op, err_timeout, err_overrun} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {cmd_valid, err_op, err_timeout, err_overrun});
    end
    checks++;
    if ({cmd_op, cmd_data} !== 40'd0) begin
      errors++;
      $display("FAIL reset_cmd: got op=%h data=%h expected 0", cmd_op, cmd_data);
    end
    #3 nRst = 1'b1;
    step(1);
  endtask

  task automatic test_basic;
    cmd_ready = 1'b1;
    send_frame(8'd0, 32'h04030201);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== 8'd0 || cmd_data !== 32'h04030201) begin
      errors++;
      $display("FAIL basic_cmd: got v=%b op=%h data=%h expected v=1 op=00 data=04030201", cmd_valid, cmd_op, cmd_data);
    end
    checks++;
    if ({err_op, err_timeout, err_overrun} !== 3'b000) begin
      errors++;
      $display("FAIL basic_errs: got %b expected 000", {err_op, err_timeout, err_overrun});
    end
    step(1);
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_one_cycle: got cmd_valid=%b expected 0", cmd_valid);
    end
  endtask

  task automatic test_back_to_back;
    cmd_ready = 1'b1;
    send_frame(8'd6, 32'hDEADBEEF);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== 8'd6 || cmd_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL b2b_first: got v=%b op=%h data=%h expected v=1 op=06 data=deadbeef", cmd_valid, cmd_op, cmd_data);
    end
    step(1);
    // SYNC lands on the very next edge after the handshake
    send_frame(8'd1, 32'h00000064);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== 8'd1 || cmd_data !== 32'h00000064) begin
      errors++;
      $display("FAIL b2b_second: got v=%b op=%h data=%h expected v=1 op=01 data=00000064", cmd_valid, cmd_op, cmd_data);
    end
    step(1);
  endtask

  task automatic test_stall;
    int bad;
    bad = 0;
    cmd_ready = 1'b0;
    send_frame(8'd5, 32'h281E140A);
    for (int i = 0; i < 20; i++) begin
      if (cmd_valid !== 1'b1 || cmd_op !== 8'd5 || cmd_data !== 32'h281E140A) bad++;
      step(1);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad);
    end
    checks++;
    if (cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_still_valid: got cmd_valid=%b expected 1", cmd_valid);
    end
    cmd_ready = 1'b1;
    step(1);
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_accept: got cmd_valid=%b expected 0", cmd_valid);
    end
  endtask

  task automatic test_illegal_op;
    cmd_ready = 1'b1;
    send_frame(8'd3, 32'h04030201);
    checks++;
    if (err_op !== 1'b1 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_op3: got err_op=%b v=%b expected err_op=1 v=0", err_op, cmd_valid);
    end
    step(1);
    checks++;
    if (err_op !== 1'b0 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse: got err_op=%b v=%b expected 0 0", err_op, cmd_valid);
    end
    send_frame(8'd8, 32'h11111111);
    checks++;
    if (err_op !== 1'b1 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_op8: got err_op=%b v=%b expected err_op=1 v=0", err_op, cmd_valid);
    end
    send_frame(8'd2, 32'hA5A55A5A);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== 8'd2 || cmd_data !== 32'hA5A55A5A || err_op !== 1'b0) begin
      errors++;
      $display("FAIL illegal_recover: got v=%b op=%h data=%h err_op=%b expected v=1 op=02 data=a5a55a5a err_op=0", cmd_valid, cmd_op, cmd_data, err_op);
    end
    step(1);
  endtask

  task automatic test_timeout;
    int seen;
    cmd_ready = 1'b1;
    send_byte(8'd100);
    send_byte(8'd6);
    send_byte(8'd10);
    seen = -1;
    for (int i = 1; i <= TIMEOUT + 5; i++) begin
      step(1);
      if (err_timeout === 1'b1 && seen < 0) seen = i;
    end
    checks++;
    if (seen !== TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_at: got pulse after %0d idle cycles expected %0d", seen, TIMEOUT + 1);
    end
    send_frame(8'd1, 32'h281E140A);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== 8'd1 || cmd_data !== 32'h281E140A) begin
      errors++;
      $display("FAIL timeout_recover: got v=%b op=%h data=%h expected v=1 op=01 data=281e140a", cmd_valid, cmd_op, cmd_data);
    end
    step(1);

    // Largest permitted gap: byte arrives TIMEOUT clocks after its predecessor
    send_byte(8'd100);
    send_byte(8'd2);
    step(TIMEOUT - 1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_data !== 32'h44332211 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_edge_ok: got v=%b data=%h to=%b expected v=1 data=44332211 to=0", cmd_valid, cmd_data, err_timeout);
    end
    step(1);

    // One clock later the timeout wins and the colliding byte is dropped
    send_byte(8'd100);
    send_byte(8'd2);
    send_byte(8'd9);
    step(TIMEOUT);
    send_byte(8'd100);
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_collide: got err_timeout=%b expected 1", err_timeout);
    end
    send_byte(8'd1);
    send_byte(8'd2);
    send_byte(8'd3);
    send_byte(8'd4);
    step(2);
    checks++;
    if (cmd_valid !== 1'b0 || err_op !== 1'b0) begin
      errors++;
      $display("FAIL timeout_drop: got v=%b err_op=%b expected 0 0", cmd_valid, err_op);
    end
  endtask

  task automatic test_overrun;
    cmd_ready = 1'b0;
    send_frame(8'd1, 32'h11223344);
    send_byte(8'd7);
    checks++;
    if (err_overrun !== 1'b1 || cmd_valid !== 1'b1 || cmd_op !== 8'd1 || cmd_data !== 32'h11223344) begin
      errors++;
      $display("FAIL overrun_hold: got ov=%b v=%b op=%h data=%h expected ov=1 v=1 op=01 data=11223344", err_overrun, cmd_valid, cmd_op, cmd_data);
    end
    checks++;
    if ({err_op, err_timeout} !== 2'b00) begin
      errors++;
      $display("FAIL overrun_excl: got err_op,err_timeout=%b expected 00", {err_op, err_timeout});
    end
    step(1);
    checks++;
    if (err_overrun !== 1'b0 || cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_pulse: got ov=%b v=%b expected ov=0 v=1", err_overrun, cmd_valid);
    end
    // Byte coincident with the handshake is still an overrun
    cmd_ready = 1'b1;
    send_byte(8'd100);
    checks++;
    if (err_overrun !== 1'b1 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_handshake: got ov=%b v=%b expected ov=1 v=0", err_overrun, cmd_valid);
    end
    send_byte(8'd5);
    send_byte(8'd1);
    send_byte(8'd2);
    send_byte(8'd3);
    step(2);
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_sync_dropped: got v=%b expected 0", cmd_valid);
    end
  endtask

  task automatic test_strays_and_reset;
    cmd_ready = 1'b1;
    send_byte(8'd7);
    send_byte(8'd9);
    send_frame(8'd2, 32'h64646464);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== 8'd2 || cmd_data !== 32'h64646464) begin
      errors++;
      $display("FAIL stray_sync_data: got v=%b op=%h data=%h expected v=1 op=02 data=64646464", cmd_valid, cmd_op, cmd_data);
    end
    step(1);

    send_byte(8'd100);
    send_byte(8'd5);
    send_byte(8'hAB);
    #2 nRst = 1'b0;
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || cmd_op !== 8'd0 || cmd_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_async: got v=%b op=%h data=%h expected all 0", cmd_valid, cmd_op, cmd_data);
    end
    step(1);
    nRst = 1'b1;
    step(1);
    send_byte(8'd2);
    send_byte(8'd3);
    send_byte(8'd4);
    step(2);
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_partial_lost: got v=%b expected 0", cmd_valid);
    end
    send_frame(8'd6, 32'hCAFEF00D);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== 8'd6 || cmd_data !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL reset_recover: got v=%b op=%h data=%h expected v=1 op=06 data=cafef00d", cmd_valid, cmd_op, cmd_data);
    end
    step(1);

    // Reset while a command is pending in HOLD
    cmd_ready = 1'b0;
    send_frame(8'd0, 32'h01020304);
    #2 nRst = 1'b0;
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || cmd_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_hold: got v=%b data=%h expected v=0 data=0", cmd_valid, cmd_data);
    end
    step(1);
    nRst = 1'b1;
    cmd_ready = 1'b1;
    step(2);
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_lost: got v=%b expected 0", cmd_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_illegal_op();
    test_timeout();
    test_overrun();
    test_strays_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
